// File: rtl/postfix_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : postfix_pkg
//  Description : Shared token codes, FSM state encoding, operator encoding and
//                error codes for the streaming postfix evaluator.
//  Revision    : 1.0 - initial release
// ============================================================================
package postfix_pkg;

    // ASCII codes carried on tok_data when tok_is_op = 1
    localparam int TOK_END = 36;   // '$'
    localparam int TOK_MUL = 42;   // '*'
    localparam int TOK_ADD = 43;   // '+'
    localparam int TOK_SUB = 45;   // '-'

    // Evaluator control states
    typedef enum logic [1:0] {
        ACCEPT = 2'd0,
        EXEC   = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Latched arithmetic operator for the EXEC cycle
    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2
    } op_t;

    // Error codes reported on err_code
    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_UNDER = 2'b01;
    localparam logic [1:0] ERR_OVER  = 2'b10;
    localparam logic [1:0] ERR_BAD   = 2'b11;

endpackage : postfix_pkg
`default_nettype wire

// File: rtl/operand_stack.sv
`default_nettype none
// ============================================================================
//  Module      : operand_stack
//  Description : Register-array operand stack. Supports a push, or a combined
//                "replace second entry and pop top" used to retire a binary
//                operation in one cycle. Only the stack pointer is reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module operand_stack #(
    parameter int N     = 8,
    parameter int DEPTH = 16,
    parameter int SPW   = $clog2(DEPTH + 1)
) (
    input  logic           CLK,
    input  logic           RST_n,
    input  logic           push,
    input  logic           pop1_wr,
    input  logic           clear,
    input  logic [N-1:0]   din,
    output logic [N-1:0]   top,
    output logic [N-1:0]   next,
    output logic [SPW-1:0] sp
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [N-1:0]   r_mem [DEPTH];
    logic [SPW-1:0] r_sp;

    logic [IW-1:0]  w_push_idx;
    logic [IW-1:0]  w_top_idx;
    logic [IW-1:0]  w_next_idx;
    logic           w_can_push;
    logic           w_can_pop;

    assign w_push_idx = IW'(r_sp);
    assign w_top_idx  = IW'(r_sp - SPW'(1));
    assign w_next_idx = IW'(r_sp - SPW'(2));
    assign w_can_push = push && (r_sp < SPW'(DEPTH));
    assign w_can_pop  = pop1_wr && (r_sp >= SPW'(2));

    // Entries above sp are unreachable, so read values are masked to zero
    assign top  = (r_sp >= SPW'(1)) ? r_mem[w_top_idx]  : '0;
    assign next = (r_sp >= SPW'(2)) ? r_mem[w_next_idx] : '0;
    assign sp   = r_sp;

    // Storage write: push into the free slot, or overwrite the second entry
    always_ff @(posedge CLK) begin
        if (w_can_push) begin
            r_mem[w_push_idx] <= din;
        end else if (w_can_pop) begin
            r_mem[w_next_idx] <= din;
        end
    end

    // Stack pointer: clear wins, then push, then pop
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_sp <= '0;
        end else if (clear) begin
            r_sp <= '0;
        end else if (w_can_push) begin
            r_sp <= r_sp + SPW'(1);
        end else if (w_can_pop) begin
            r_sp <= r_sp - SPW'(1);
        end
    end

endmodule : operand_stack
`default_nettype wire

// File: rtl/postfix_evaluator.sv
`default_nettype none
// ============================================================================
//  Module      : postfix_evaluator
//  Description : Streaming evaluator for tagged postfix tokens. Operands are
//                stacked, + - * retire in a one-cycle EXEC state, '$' returns
//                the final value or a sticky error code over a valid/ready port.
//  Revision    : 1.0 - initial release
// ============================================================================
module postfix_evaluator
    import postfix_pkg::*;
#(
    parameter int N     = 8,
    parameter int DEPTH = 16
) (
    input  logic         CLK,
    input  logic         RST_n,
    input  logic         tok_valid,
    output logic         tok_ready,
    input  logic [N-1:0] tok_data,
    input  logic         tok_is_op,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [N-1:0] result,
    output logic         err,
    output logic [1:0]   err_code
);

    localparam int SPW = $clog2(DEPTH + 1);

    state_t         r_state;
    op_t            r_op;
    logic           r_tok_ready;
    logic           r_res_valid;
    logic [N-1:0]   r_result;
    logic           r_err;
    logic [1:0]     r_err_code;
    logic           r_err_pend;
    logic [1:0]     r_err_code_pend;

    logic           w_accept;
    logic           w_is_end;
    logic           w_is_arith;
    logic           w_push;
    logic           w_pop;
    logic           w_clear;
    logic [N-1:0]   w_top;
    logic [N-1:0]   w_next;
    logic [N-1:0]   w_alu;
    logic [SPW-1:0] w_sp;
    op_t            w_op_dec;

    // tok_ready is registered and only ever high in ACCEPT
    assign w_accept   = r_tok_ready && tok_valid;
    assign w_is_end   = (tok_data == N'(TOK_END));
    assign w_is_arith = (tok_data == N'(TOK_ADD)) || (tok_data == N'(TOK_SUB))
                     || (tok_data == N'(TOK_MUL));

    // After an error the stack is frozen; overflowing pushes never land
    assign w_push  = w_accept && !tok_is_op && !r_err_pend && (w_sp != SPW'(DEPTH));
    assign w_pop   = (r_state == EXEC);
    assign w_clear = (r_state == DONE) && res_ready;

    operand_stack #(
        .N     (N),
        .DEPTH (DEPTH),
        .SPW   (SPW)
    ) u_stack (
        .CLK     (CLK),
        .RST_n   (RST_n),
        .push    (w_push),
        .pop1_wr (w_pop),
        .clear   (w_clear),
        .din     (w_pop ? w_alu : tok_data),
        .top     (w_top),
        .next    (w_next),
        .sp      (w_sp)
    );

    // Operator code decode for latching on acceptance
    always_comb begin
        w_op_dec = OP_ADD;
        if (tok_data == N'(TOK_SUB)) begin
            w_op_dec = OP_SUB;
        end else if (tok_data == N'(TOK_MUL)) begin
            w_op_dec = OP_MUL;
        end
    end

    // ALU: A = entry below top, B = top; all results wrap modulo 2^N
    always_comb begin
        w_alu = w_next + w_top;
        case (r_op)
            OP_SUB:  w_alu = w_next - w_top;
            OP_MUL:  w_alu = w_next * w_top;
            default: w_alu = w_next + w_top;
        endcase
    end

    // Control FSM with sticky error tracking and registered result port
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_state         <= ACCEPT;
            r_op            <= OP_ADD;
            r_tok_ready     <= 1'b0;
            r_res_valid     <= 1'b0;
            r_result        <= '0;
            r_err           <= 1'b0;
            r_err_code      <= ERR_NONE;
            r_err_pend      <= 1'b0;
            r_err_code_pend <= ERR_NONE;
        end else begin
            case (r_state)
                ACCEPT: begin
                    r_tok_ready <= 1'b1;
                    if (w_accept) begin
                        if (!tok_is_op) begin
                            if (!r_err_pend && (w_sp == SPW'(DEPTH))) begin
                                r_err_pend      <= 1'b1;
                                r_err_code_pend <= ERR_OVER;
                            end
                        end else if (w_is_end) begin
                            r_state     <= DONE;
                            r_tok_ready <= 1'b0;
                            r_res_valid <= 1'b1;
                            if (r_err_pend) begin
                                r_err      <= 1'b1;
                                r_err_code <= r_err_code_pend;
                                r_result   <= '0;
                            end else if (w_sp != SPW'(1)) begin
                                r_err           <= 1'b1;
                                r_err_code      <= ERR_BAD;
                                r_result        <= '0;
                                r_err_pend      <= 1'b1;
                                r_err_code_pend <= ERR_BAD;
                            end else begin
                                r_err      <= 1'b0;
                                r_err_code <= ERR_NONE;
                                r_result   <= w_top;
                            end
                        end else if (w_is_arith) begin
                            if (!r_err_pend) begin
                                if (w_sp < SPW'(2)) begin
                                    r_err_pend      <= 1'b1;
                                    r_err_code_pend <= ERR_UNDER;
                                end else begin
                                    r_op        <= w_op_dec;
                                    r_state     <= EXEC;
                                    r_tok_ready <= 1'b0;
                                end
                            end
                        end else if (!r_err_pend) begin
                            r_err_pend      <= 1'b1;
                            r_err_code_pend <= ERR_BAD;
                        end
                    end
                end
                EXEC: begin
                    r_state     <= ACCEPT;
                    r_tok_ready <= 1'b1;
                end
                DONE: begin
                    if (res_ready) begin
                        r_state         <= ACCEPT;
                        r_tok_ready     <= 1'b1;
                        r_res_valid     <= 1'b0;
                        r_result        <= '0;
                        r_err           <= 1'b0;
                        r_err_code      <= ERR_NONE;
                        r_err_pend      <= 1'b0;
                        r_err_code_pend <= ERR_NONE;
                    end
                end
                default: begin
                    r_state     <= ACCEPT;
                    r_tok_ready <= 1'b0;
                end
            endcase
        end
    end

    assign tok_ready = r_tok_ready;
    assign res_valid = r_res_valid;
    assign result    = r_result;
    assign err       = r_err;
    assign err_code  = r_err_code;

endmodule : postfix_evaluator
`default_nettype wire

// File: tb/tb_postfix_evaluator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_postfix_evaluator
//  Description : Directed self-checking bench for postfix_evaluator (N = 8,
//                DEPTH = 4) with hand-computed expected results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_postfix_evaluator;

    localparam int N     = 8;
    localparam int DEPTH = 4;

    logic         CLK       = 1'b0;
    logic         RST_n     = 1'b0;
    logic         tok_valid = 1'b0;
    logic [N-1:0] tok_data  = '0;
    logic         tok_is_op = 1'b0;
    logic         res_ready = 1'b0;
    logic         tok_ready;
    logic         res_valid;
    logic [N-1:0] result;
    logic         err;
    logic [1:0]   err_code;

    int n_checks = 0;
    int n_pass   = 0;

    postfix_evaluator #(
        .N     (N),
        .DEPTH (DEPTH)
    ) dut (
        .CLK       (CLK),
        .RST_n     (RST_n),
        .tok_valid (tok_valid),
        .tok_ready (tok_ready),
        .tok_data  (tok_data),
        .tok_is_op (tok_is_op),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .result    (result),
        .err       (err),
        .err_code  (err_code)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Present one token and hold it until the evaluator accepts it
    task automatic send(input logic is_op, input logic [7:0] d);
        int waited;
        waited = 0;
        @(negedge CLK);
        tok_valid = 1'b1;
        tok_is_op = is_op;
        tok_data  = d;
        while (!tok_ready && waited < 20) begin
            @(negedge CLK);
            waited++;
        end
        if (!tok_ready) begin
            check("tok_accept_timeout", 32'd0, 32'd1);
        end else begin
            @(posedge CLK);
            #1;
        end
        tok_valid = 1'b0;
        tok_is_op = 1'b0;
    endtask

    task automatic opnd(input logic [7:0] d);
        send(1'b0, d);
    endtask

    task automatic oper(input logic [7:0] c);
        send(1'b1, c);
    endtask

    // Wait for the result, compare it, then complete the handshake
    task automatic get_result(input string tag, input logic [7:0] exp_res,
                              input logic exp_err, input logic [1:0] exp_code);
        int waited;
        waited = 0;
        while (!res_valid && waited < 20) begin
            @(negedge CLK);
            waited++;
        end
        check({tag, "_valid"},  32'(res_valid), 32'd1);
        check({tag, "_result"}, 32'(result),    32'(exp_res));
        check({tag, "_err"},    32'(err),       32'(exp_err));
        check({tag, "_code"},   32'(err_code),  32'(exp_code));
        @(negedge CLK);
        res_ready = 1'b1;
        @(posedge CLK);
        #1;
        res_ready = 1'b0;
        check({tag, "_ready_after_hs"}, 32'(tok_ready), 32'd1);
        check({tag, "_valid_after_hs"}, 32'(res_valid), 32'd0);
    endtask

    // Watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values
        repeat (2) @(negedge CLK);
        check("rst_tok_ready", 32'(tok_ready), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_result",    32'(result),    32'd0);
        check("rst_err",       32'(err),       32'd0);
        check("rst_err_code",  32'(err_code),  32'd0);
        RST_n = 1'b1;
        #1;
        check("rel_tok_ready_low", 32'(tok_ready), 32'd0);
        @(posedge CLK);
        #1;
        check("rel_tok_ready_high", 32'(tok_ready), 32'd1);

        // 3 4 + 2 * $ = 14
        opnd(8'd3); opnd(8'd4); oper(8'd43);
        check("exec_tok_ready_low", 32'(tok_ready), 32'd0);
        opnd(8'd2); oper(8'd42); oper(8'd36);
        check("end_latency_valid", 32'(res_valid), 32'd1);
        get_result("t1", 8'd14, 1'b0, 2'b00);

        // 5 9 - $ = 252 (wrap)
        opnd(8'd5); opnd(8'd9); oper(8'd45); oper(8'd36);
        get_result("t2_sub_wrap", 8'd252, 1'b0, 2'b00);

        // 20 13 * $ = 260 mod 256 = 4
        opnd(8'd20); opnd(8'd13); oper(8'd42); oper(8'd36);
        get_result("t3_mul_wrap", 8'd4, 1'b0, 2'b00);

        // 1 + 7 $ -> underflow, the 7 is accepted and discarded
        opnd(8'd1); oper(8'd43); opnd(8'd7); oper(8'd36);
        get_result("t4_under", 8'd0, 1'b1, 2'b01);

        // Five operands with DEPTH = 4 -> overflow
        for (int i = 1; i <= 5; i++) opnd(8'(i));
        oper(8'd36);
        get_result("t5_over", 8'd0, 1'b1, 2'b10);

        // 1 2 $ -> leftover operands
        opnd(8'd1); opnd(8'd2); oper(8'd36);
        get_result("t6_leftover", 8'd0, 1'b1, 2'b11);

        // 1 '/' $ -> bad code
        opnd(8'd1); oper(8'd47); oper(8'd36);
        get_result("t7_badcode", 8'd0, 1'b1, 2'b11);

        // Backpressure: 6 7 + $ = 13 held for 5 cycles
        opnd(8'd6); opnd(8'd7); oper(8'd43); oper(8'd36);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check("bp_valid",     32'(res_valid), 32'd1);
            check("bp_result",    32'(result),    32'd13);
            check("bp_err",       32'(err),       32'd0);
            check("bp_tok_ready", 32'(tok_ready), 32'd0);
        end
        get_result("t8_bp", 8'd13, 1'b0, 2'b00);
        // Back-to-back expression from an empty stack: 9 3 - $ = 6
        opnd(8'd9); opnd(8'd3); oper(8'd45); oper(8'd36);
        get_result("t8_b2b", 8'd6, 1'b0, 2'b00);

        // Reset mid-expression after 3 4
        opnd(8'd3); opnd(8'd4);
        @(negedge CLK);
        RST_n = 1'b0;
        #1;
        check("mid_rst_tok_ready", 32'(tok_ready), 32'd0);
        check("mid_rst_res_valid", 32'(res_valid), 32'd0);
        check("mid_rst_result",    32'(result),    32'd0);
        check("mid_rst_err",       32'(err),       32'd0);
        check("mid_rst_err_code",  32'(err_code),  32'd0);
        @(negedge CLK);
        RST_n = 1'b1;
        opnd(8'd2); opnd(8'd2); oper(8'd43); oper(8'd36);
        get_result("t9_after_rst", 8'd4, 1'b0, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_postfix_evaluator
`default_nettype wire
